// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and downstream hold.
// Optional statistics counters are compiled in with `define ID_EX_HAZARD_STATS_EN.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_RegWrite,
  input  logic              id_MemWrite,
  input  logic              id_MemRead,
  input  logic              id_ALUSrc,
  input  logic [4:0]        id_ALUOp,
  input  logic [4:0]        id_NPCOp,
  input  logic [1:0]        id_WDSel,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_RegWrite,
  output logic              ex_MemWrite,
  output logic              ex_MemRead,
  output logic              ex_ALUSrc,
  output logic [4:0]        ex_ALUOp,
  output logic [4:0]        ex_NPCOp,
  output logic [1:0]        ex_WDSel
`ifdef ID_EX_HAZARD_STATS_EN
  ,
  output logic [31:0]       stat_bubbles,
  output logic [31:0]       stat_flushes
`endif
);

  logic hz;
  logic load_bubble;

  // A load in EX whose rd feeds the ID instruction cannot forward in time.
  assign hz = ex_valid & ex_MemRead & (ex_rd != '0) & id_valid &
              ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));

  assign stall       = ~rst & ~flush & (ex_hold | hz);
  assign load_bubble = rst | flush | (~ex_hold & hz);

  always_ff @(posedge clk) begin
    if (load_bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_RegWrite <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_ALUOp    <= '0;
      ex_NPCOp    <= '0;
      ex_WDSel    <= '0;
    end else if (!ex_hold) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_rd1      <= id_rd1;
      ex_rd2      <= id_rd2;
      ex_imm      <= id_imm;
      ex_RegWrite <= id_RegWrite;
      ex_MemWrite <= id_MemWrite;
      ex_MemRead  <= id_MemRead;
      ex_ALUSrc   <= id_ALUSrc;
      ex_ALUOp    <= id_ALUOp;
      ex_NPCOp    <= id_NPCOp;
      ex_WDSel    <= id_WDSel;
    end
  end

`ifdef ID_EX_HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bubbles <= '0;
      stat_flushes <= '0;
    end else begin
      if (flush)
        stat_flushes <= stat_flushes + 32'd1;
      else if (!ex_hold && hz)
        stat_bubbles <= stat_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table plus randomized run
// against a rule-level reference model (stats checked when ID_EX_HAZARD_STATS_EN is defined).
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        RegWrite;
    logic        MemWrite;
    logic        MemRead;
    logic        ALUSrc;
    logic [4:0]  ALUOp;
    logic [4:0]  NPCOp;
    logic [1:0]  WDSel;
  } fields_t;

  typedef struct packed {
    fields_t f;
    logic    rs1_used;
    logic    rs2_used;
  } id_t;

  typedef struct {
    id_t        id;
    bit         r;
    bit         fl;
    bit         h;
    bit         exp_stall;
    bit         exp_valid;
    logic [4:0] exp_rd;
    logic [4:0] exp_alu;
    bit         exp_mw;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, flush, ex_hold, stall;
  logic        id_valid, id_rs1_used, id_rs2_used;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_ALUOp, id_NPCOp;
  logic        id_RegWrite, id_MemWrite, id_MemRead, id_ALUSrc;
  logic [1:0]  id_WDSel;
  logic        ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_ALUOp, ex_NPCOp;
  logic [1:0]  ex_WDSel;
`ifdef ID_EX_HAZARD_STATS_EN
  logic [31:0] stat_bubbles, stat_flushes;
`endif

  fields_t act;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead),
    .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp), .id_NPCOp(id_NPCOp), .id_WDSel(id_WDSel),
    .flush(flush), .ex_hold(ex_hold), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead),
    .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_NPCOp(ex_NPCOp), .ex_WDSel(ex_WDSel)
`ifdef ID_EX_HAZARD_STATS_EN
    , .stat_bubbles(stat_bubbles), .stat_flushes(stat_flushes)
`endif
  );

  always_comb begin
    act = '{valid: ex_valid, pc: ex_pc, rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd,
            rd1: ex_rd1, rd2: ex_rd2, imm: ex_imm, RegWrite: ex_RegWrite,
            MemWrite: ex_MemWrite, MemRead: ex_MemRead, ALUSrc: ex_ALUSrc,
            ALUOp: ex_ALUOp, NPCOp: ex_NPCOp, WDSel: ex_WDSel};
  end

  function automatic id_t mk(bit v, logic [4:0] rs1, bit u1, logic [4:0] rs2, bit u2,
                             logic [4:0] rd, bit rw, bit mw, bit mr, logic [4:0] alu);
    id_t d;
    d.f.valid    = v;
    d.f.pc       = 32'h0000_1000 + {27'd0, rd} * 4;
    d.f.rs1      = rs1;
    d.f.rs2      = rs2;
    d.f.rd       = rd;
    d.f.rd1      = 32'hA000_0000 | {27'd0, rs1};
    d.f.rd2      = 32'hB000_0000 | {27'd0, rs2};
    d.f.imm      = 32'd4;
    d.f.RegWrite = rw;
    d.f.MemWrite = mw;
    d.f.MemRead  = mr;
    d.f.ALUSrc   = mr | mw;
    d.f.ALUOp    = alu;
    d.f.NPCOp    = 5'd0;
    d.f.WDSel    = mr ? 2'b01 : 2'b00;
    d.rs1_used   = u1;
    d.rs2_used   = u2;
    return d;
  endfunction

  function automatic vec_t mkv(id_t d, bit r, bit fl, bit h, bit es, bit ev,
                               logic [4:0] erd, logic [4:0] ealu, bit emw);
    vec_t x;
    x.id = d; x.r = r; x.fl = fl; x.h = h; x.exp_stall = es; x.exp_valid = ev;
    x.exp_rd = erd; x.exp_alu = ealu; x.exp_mw = emw;
    return x;
  endfunction

  // Hazard rule as stated for the pipeline: a valid load in EX writing a
  // nonzero register that the valid ID instruction actually reads.
  function automatic bit model_hz(fields_t ex, id_t d);
    bit reads_it;
    if (!(ex.valid && ex.MemRead && ex.rd != 5'd0 && d.f.valid)) return 1'b0;
    reads_it = (d.rs1_used && d.f.rs1 == ex.rd) || (d.rs2_used && d.f.rs2 == ex.rd);
    return reads_it;
  endfunction

  task automatic applyStimulus(id_t d, bit r, bit fl, bit h);
    rst         = r;
    flush       = fl;
    ex_hold     = h;
    id_valid    = d.f.valid;
    id_pc       = d.f.pc;
    id_rs1      = d.f.rs1;
    id_rs2      = d.f.rs2;
    id_rd       = d.f.rd;
    id_rd1      = d.f.rd1;
    id_rd2      = d.f.rd2;
    id_imm      = d.f.imm;
    id_RegWrite = d.f.RegWrite;
    id_MemWrite = d.f.MemWrite;
    id_MemRead  = d.f.MemRead;
    id_ALUSrc   = d.f.ALUSrc;
    id_ALUOp    = d.f.ALUOp;
    id_NPCOp    = d.f.NPCOp;
    id_WDSel    = d.f.WDSel;
    id_rs1_used = d.rs1_used;
    id_rs2_used = d.rs2_used;
  endtask

  task automatic checkOutput(string name, logic [191:0] actual, logic [191:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  id_t  idle, lw5, add6, lw0, add6x0, addi6, sw, add9, add55, nv;
  fields_t model;
  id_t  rnd;
  bit   r_r, r_fl, r_h, exp_stall;
  int unsigned exp_bub, exp_fl;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lw5    = mk(1, 1, 1, 0, 0, 5, 1, 0, 1, 5'b00011);
    add6   = mk(1, 5, 1, 2, 1, 6, 1, 0, 0, 5'b00011);
    lw0    = mk(1, 1, 1, 0, 0, 0, 1, 0, 1, 5'b00011);
    add6x0 = mk(1, 0, 1, 2, 1, 6, 1, 0, 0, 5'b00011);
    addi6  = mk(1, 7, 1, 5, 0, 6, 1, 0, 0, 5'b00011);
    sw     = mk(1, 1, 1, 2, 1, 0, 0, 1, 0, 5'b00011);
    add9   = mk(1, 3, 1, 4, 1, 9, 1, 0, 0, 5'b00011);
    add55  = mk(1, 5, 1, 5, 1, 6, 1, 0, 0, 5'b00011);
    nv     = mk(0, 5, 1, 5, 1, 7, 1, 0, 0, 5'b00100);

    // id, rst, flush, hold, exp stall, exp valid/rd/ALUOp/MemWrite after the edge
    vecs.push_back(mkv(lw5,    0, 0, 0, 0, 1, 5, 3, 0));
    vecs.push_back(mkv(add6,   0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(add6,   0, 0, 0, 0, 1, 6, 3, 0));
    vecs.push_back(mkv(lw0,    0, 0, 0, 0, 1, 0, 3, 0));
    vecs.push_back(mkv(add6x0, 0, 0, 0, 0, 1, 6, 3, 0));
    vecs.push_back(mkv(lw5,    0, 0, 0, 0, 1, 5, 3, 0));
    vecs.push_back(mkv(addi6,  0, 0, 0, 0, 1, 6, 3, 0));
    vecs.push_back(mkv(lw5,    0, 0, 0, 0, 1, 5, 3, 0));
    vecs.push_back(mkv(add6,   0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(sw,     0, 0, 0, 0, 1, 0, 3, 1));
    vecs.push_back(mkv(add9,   0, 0, 1, 1, 1, 0, 3, 1));
    vecs.push_back(mkv(add9,   0, 0, 1, 1, 1, 0, 3, 1));
    vecs.push_back(mkv(add9,   0, 0, 1, 1, 1, 0, 3, 1));
    vecs.push_back(mkv(add9,   0, 0, 0, 0, 1, 9, 3, 0));
    vecs.push_back(mkv(lw5,    0, 0, 0, 0, 1, 5, 3, 0));
    vecs.push_back(mkv(add55,  0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(add55,  0, 0, 0, 0, 1, 6, 3, 0));
    vecs.push_back(mkv(lw5,    0, 0, 0, 0, 1, 5, 3, 0));
    vecs.push_back(mkv(nv,     0, 0, 0, 0, 0, 7, 4, 0));
    vecs.push_back(mkv(sw,     0, 0, 0, 0, 1, 0, 3, 1));
    vecs.push_back(mkv(add9,   0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(lw5,    0, 0, 0, 0, 1, 5, 3, 0));
    vecs.push_back(mkv(add6,   1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(add6,   0, 0, 0, 0, 1, 6, 3, 0));

    applyStimulus(lw5, 1, 0, 0);
    nextEdge();
    nextEdge();
    checkOutput("reset_ex_fields", 192'(act), 192'(0));
    checkOutput("reset_stall", 192'(stall), 192'(0));
`ifdef ID_EX_HAZARD_STATS_EN
    checkOutput("reset_stat_bubbles", 192'(stat_bubbles), 192'(0));
    checkOutput("reset_stat_flushes", 192'(stat_flushes), 192'(0));
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].id, vecs[i].r, vecs[i].fl, vecs[i].h);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_stall", i), 192'(stall), 192'(vecs[i].exp_stall));
      nextEdge();
      checkOutput($sformatf("vec%0d_valid", i), 192'(ex_valid), 192'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_rd", i), 192'(ex_rd), 192'(vecs[i].exp_rd));
      checkOutput($sformatf("vec%0d_alu", i), 192'(ex_ALUOp), 192'(vecs[i].exp_alu));
      checkOutput($sformatf("vec%0d_memwrite", i), 192'(ex_MemWrite), 192'(vecs[i].exp_mw));
      if (vecs[i].r)
        checkOutput($sformatf("vec%0d_reset_all", i), 192'(act), 192'(0));
    end

    // Randomized run against the reference model.
    applyStimulus(idle, 1, 0, 0);
    nextEdge();
    model   = '0;
    exp_bub = 0;
    exp_fl  = 0;
    for (int c = 0; c < 400; c++) begin
      rnd.f          = fields_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      rnd.f.rs1      = 5'($urandom_range(0, 3));
      rnd.f.rs2      = 5'($urandom_range(0, 3));
      rnd.f.rd       = 5'($urandom_range(0, 3));
      rnd.f.valid    = ($urandom_range(0, 4) != 0);
      rnd.f.MemRead  = ($urandom_range(0, 1) != 0);
      rnd.rs1_used   = ($urandom_range(0, 3) != 0);
      rnd.rs2_used   = ($urandom_range(0, 1) != 0);
      r_r            = ($urandom_range(0, 29) == 0);
      r_fl           = ($urandom_range(0, 9) == 0);
      r_h            = ($urandom_range(0, 5) == 0);
      applyStimulus(rnd, r_r, r_fl, r_h);
      exp_stall = !r_r && !r_fl && (r_h || model_hz(model, rnd));
      @(negedge clk);
      checkOutput($sformatf("rnd%0d_stall", c), 192'(stall), 192'(exp_stall));
      if (r_r) begin
        exp_bub = 0;
        exp_fl  = 0;
      end else if (r_fl) begin
        exp_fl++;
      end else if (!r_h && model_hz(model, rnd)) begin
        exp_bub++;
      end
      if (r_r || r_fl)                    model = '0;
      else if (r_h)                       model = model;
      else if (model_hz(model, rnd))      model = '0;
      else                                model = rnd.f;
      nextEdge();
      checkOutput($sformatf("rnd%0d_ex", c), 192'(act), 192'(model));
`ifdef ID_EX_HAZARD_STATS_EN
      checkOutput($sformatf("rnd%0d_bubbles", c), 192'(stat_bubbles), 192'(exp_bub));
      checkOutput($sformatf("rnd%0d_flushes", c), 192'(stat_flushes), 192'(exp_fl));
`endif
    end

`ifdef ID_EX_HAZARD_STATS_EN
    // Two load-use pairs and one flush after a fresh reset.
    applyStimulus(idle, 1, 0, 0); nextEdge();
    applyStimulus(lw5, 0, 0, 0);  nextEdge();
    applyStimulus(add6, 0, 0, 0); nextEdge();
    applyStimulus(add6, 0, 0, 0); nextEdge();
    applyStimulus(lw5, 0, 0, 0);  nextEdge();
    applyStimulus(add55, 0, 0, 0); nextEdge();
    applyStimulus(add55, 0, 0, 0); nextEdge();
    applyStimulus(idle, 0, 1, 0); nextEdge();
    applyStimulus(idle, 0, 0, 0); nextEdge();
    checkOutput("stats_bubbles_two", 192'(stat_bubbles), 192'(2));
    checkOutput("stats_flushes_one", 192'(stat_flushes), 192'(1));
    applyStimulus(idle, 1, 0, 0); nextEdge();
    checkOutput("stats_bubbles_clear", 192'(stat_bubbles), 192'(0));
    checkOutput("stats_flushes_clear", 192'(stat_flushes), 192'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
